// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared types and default sizes for the multi-port register
//               file slice.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    typedef enum logic [0:0] {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_e;

    localparam int c_def_data_width = 32;
    localparam int c_def_depth      = 32;

endpackage
`default_nettype wire

// File: rtl/regfile_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_if
// Description : Read, write and allocate bundle between issue/writeback
//               logic (master) and the register file (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = 5,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1
);
    logic                         ready;
    logic [NUM_RD*ADDR_W-1:0]     rd_addr;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]            rd_busy;
    logic [NUM_WR-1:0]            wr_en;
    logic [NUM_WR*ADDR_W-1:0]     wr_addr;
    logic [NUM_WR*DATA_WIDTH-1:0] wr_data;
    logic                         alloc_en;
    logic [ADDR_W-1:0]            alloc_addr;

    modport master (
        input  ready, rd_data, rd_busy,
        output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr
    );

    modport slave (
        output ready, rd_data, rd_busy,
        input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr
    );
endinterface
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Per-register busy bits: writes clear, allocation sets.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int NUM_WR = 1,
    parameter int NUM_RD = 2
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic [NUM_WR-1:0]        i_clr_en,
    input  wire logic [NUM_WR*ADDR_W-1:0] i_clr_addr,
    input  wire logic                     i_set_en,
    input  wire logic [ADDR_W-1:0]        i_set_addr,
    input  wire logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
    output logic      [NUM_RD-1:0]        o_rd_busy
);

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_next;

    // Set is applied after the clears so a same-cycle allocation wins.
    always_comb begin
        w_busy_next = r_busy;
        for (int j = 0; j < NUM_WR; j++) begin
            if (i_clr_en[j]) begin
                w_busy_next[i_clr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (i_set_en) begin
            w_busy_next[i_set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        assign o_rd_busy[k] = r_busy[i_rd_addr[k*ADDR_W +: ADDR_W]];
    end

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp
// Description : Parametrised multi-port register file with optional write
//               bypass, busy scoreboard and sequenced clear after reset.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = c_def_data_width,
    parameter int DEPTH      = c_def_depth,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  wire logic clk,
    input  wire logic rst,
    regfile_if.slave  bus
);

    localparam logic [ADDR_W-1:0] c_last = ADDR_W'(DEPTH - 1);

    rf_state_e             r_state;
    rf_state_e             w_state_next;
    logic                  w_run;
    logic                  w_clear_we;
    logic [ADDR_W-1:0]     r_cnt;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [NUM_WR-1:0]     w_wr_ok;
    logic                  w_alloc_ok;
    logic [NUM_RD-1:0]     w_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RF_CLEAR;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_run        = 1'b0;
        w_clear_we   = 1'b0;
        case (r_state)
            RF_CLEAR: begin
                w_clear_we = 1'b1;
                if (r_cnt == c_last) begin
                    w_state_next = RF_RUN;
                end
            end
            RF_RUN: begin
                w_run = 1'b1;
            end
            default: begin
                w_state_next = RF_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_clear_we) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.ready = w_run;

    // Qualified write/alloc strobes: RUN only, zero register filtered out.
    for (genvar j = 0; j < NUM_WR; j++) begin : g_wr
        assign w_wr_ok[j] = w_run && !rst && bus.wr_en[j] &&
                            !(ZERO_REG != 0 && bus.wr_addr[j*ADDR_W +: ADDR_W] == '0);
    end

    assign w_alloc_ok = w_run && !rst && bus.alloc_en &&
                        !(ZERO_REG != 0 && bus.alloc_addr == '0);

    // Later ports are assigned last, so the highest index wins on conflicts.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_clear_we) begin
                r_mem[r_cnt] <= '0;
            end else begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (w_wr_ok[j]) begin
                        r_mem[bus.wr_addr[j*ADDR_W +: ADDR_W]] <=
                            bus.wr_data[j*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0]     w_ra;
        logic [DATA_WIDTH-1:0] w_rd;

        assign w_ra = bus.rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            w_rd = r_mem[w_ra];
            if (BYPASS != 0) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (w_wr_ok[j] && bus.wr_addr[j*ADDR_W +: ADDR_W] == w_ra) begin
                        w_rd = bus.wr_data[j*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
            if (!w_run || (ZERO_REG != 0 && w_ra == '0)) begin
                w_rd = '0;
            end
        end

        assign bus.rd_data[k*DATA_WIDTH +: DATA_WIDTH] = w_rd;
    end

    regfile_scoreboard #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .NUM_WR (NUM_WR),
        .NUM_RD (NUM_RD)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .i_clr_en   (w_wr_ok),
        .i_clr_addr (bus.wr_addr),
        .i_set_en   (w_alloc_ok),
        .i_set_addr (bus.alloc_addr),
        .i_rd_addr  (bus.rd_addr),
        .o_rd_busy  (w_busy)
    );

    assign bus.rd_busy = w_busy & {NUM_RD{w_run}};

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_mp
// Description : Scoreboard bench for regfile_mp; unit A has two write ports
//               with bypass, unit B one write port without bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    regfile_if #(.DATA_WIDTH(DW), .ADDR_W(AW), .NUM_RD(2), .NUM_WR(2)) bus_a ();
    regfile_if #(.DATA_WIDTH(DW), .ADDR_W(AW), .NUM_RD(2), .NUM_WR(1)) bus_b ();

    regfile_mp #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_RD(2), .NUM_WR(2), .BYPASS(1), .ZERO_REG(1)
    ) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    regfile_mp #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_RD(2), .NUM_WR(1), .BYPASS(0), .ZERO_REG(1)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    // kind: 0 = rd_data, 1 = rd_busy, 2 = ready
    int          q_dut  [$];
    int          q_kind [$];
    int          q_port [$];
    logic [31:0] q_exp  [$];
    string       q_name [$];

    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [31:0] actual(input int dut, input int kind, input int port);
        logic [31:0] v;
        v = '0;
        case (kind)
            0: v = (dut == 0) ? bus_a.rd_data[port*DW +: DW] : bus_b.rd_data[port*DW +: DW];
            1: v = {31'b0, (dut == 0) ? bus_a.rd_busy[port[0]] : bus_b.rd_busy[port[0]]};
            default: v = {31'b0, (dut == 0) ? bus_a.ready : bus_b.ready};
        endcase
        return v;
    endfunction

    int          m_dut, m_kind, m_port;
    logic [31:0] m_exp, m_act;
    string       m_name;

    always @(negedge clk) begin
        while (q_exp.size() > 0) begin
            m_dut  = q_dut.pop_front();
            m_kind = q_kind.pop_front();
            m_port = q_port.pop_front();
            m_exp  = q_exp.pop_front();
            m_name = q_name.pop_front();
            m_act  = actual(m_dut, m_kind, m_port);
            n_cmp++;
            if (m_act !== m_exp) begin
                n_err++;
                $display("FAIL %s (dut %0d port %0d): got %h expected %h",
                         m_name, m_dut, m_port, m_act, m_exp);
            end
        end
    end

    task automatic expect_v(input int dut, input int kind, input int port,
                            input logic [31:0] e, input string nm);
        q_dut.push_back(dut);
        q_kind.push_back(kind);
        q_port.push_back(port);
        q_exp.push_back(e);
        q_name.push_back(nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus_a.wr_en    = '0;
        bus_a.alloc_en = 1'b0;
        bus_b.wr_en    = '0;
        bus_b.alloc_en = 1'b0;
    endtask

    task automatic set_rd(input int dut, input int port, input int addr);
        if (dut == 0) bus_a.rd_addr[port*AW +: AW] = AW'(addr);
        else          bus_b.rd_addr[port*AW +: AW] = AW'(addr);
    endtask

    task automatic wr(input int dut, input int port, input int addr, input logic [31:0] data);
        if (dut == 0) begin
            bus_a.wr_en[port[0]]          = 1'b1;
            bus_a.wr_addr[port*AW +: AW]  = AW'(addr);
            bus_a.wr_data[port*DW +: DW]  = data;
        end else begin
            bus_b.wr_en   = 1'b1;
            bus_b.wr_addr = AW'(addr);
            bus_b.wr_data = data;
        end
    endtask

    task automatic alloc(input int dut, input int addr);
        if (dut == 0) begin
            bus_a.alloc_en   = 1'b1;
            bus_a.alloc_addr = AW'(addr);
        end else begin
            bus_b.alloc_en   = 1'b1;
            bus_b.alloc_addr = AW'(addr);
        end
    endtask

    task automatic read_all_zero(input string nm);
        for (int a = 0; a < DEPTH; a++) begin
            set_rd(0, 0, a);
            set_rd(0, 1, DEPTH - 1 - a);
            set_rd(1, 0, a);
            expect_v(0, 0, 0, 32'h0, nm);
            expect_v(0, 0, 1, 32'h0, nm);
            expect_v(1, 0, 0, 32'h0, nm);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        bus_a.rd_addr = '0; bus_a.wr_addr = '0; bus_a.wr_data = '0; bus_a.alloc_addr = '0;
        bus_b.rd_addr = '0; bus_b.wr_addr = '0; bus_b.wr_data = '0; bus_b.alloc_addr = '0;
        tick();
        tick();
        expect_v(0, 2, 0, 32'h0, "ready_in_reset");
        rst = 1'b0;

        // Clear sequence: ready low for exactly DEPTH cycles, writes/allocs lost
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            if (i == 5) begin
                wr(0, 0, 5, 32'h55);
                wr(1, 0, 5, 32'h55);
                alloc(0, 5);
                set_rd(0, 0, 5);
                expect_v(0, 0, 0, 32'h0, "rd_during_clear");
                expect_v(0, 1, 0, 32'h0, "busy_during_clear");
            end
            expect_v(0, 2, 0, 32'h0, "ready_clear_a");
            expect_v(1, 2, 0, 32'h0, "ready_clear_b");
            tick();
        end
        idle();
        expect_v(0, 2, 0, 32'h1, "ready_rise_a");
        expect_v(1, 2, 0, 32'h1, "ready_rise_b");
        set_rd(0, 0, 5);
        expect_v(0, 1, 0, 32'h0, "busy_r5_after_clear");
        read_all_zero("clear_readback");

        // Write r5 with/without bypass
        wr(0, 0, 5, 32'hDEADBEEF);
        wr(1, 0, 5, 32'hDEADBEEF);
        set_rd(0, 0, 5);
        set_rd(1, 0, 5);
        expect_v(0, 0, 0, 32'hDEADBEEF, "bypass_same_cycle");
        expect_v(1, 0, 0, 32'h0, "nobypass_same_cycle");
        tick();
        idle();
        expect_v(0, 0, 0, 32'hDEADBEEF, "stored_r5_a");
        expect_v(1, 0, 0, 32'hDEADBEEF, "stored_r5_b");
        tick();

        // Zero register
        wr(0, 0, 0, 32'h1234);
        wr(1, 0, 0, 32'h1234);
        alloc(0, 0);
        alloc(1, 0);
        set_rd(0, 1, 0);
        set_rd(1, 1, 0);
        expect_v(0, 0, 1, 32'h0, "r0_bypass_a");
        expect_v(1, 0, 1, 32'h0, "r0_same_b");
        tick();
        idle();
        expect_v(0, 0, 1, 32'h0, "r0_stored_a");
        expect_v(1, 0, 1, 32'h0, "r0_stored_b");
        expect_v(0, 1, 1, 32'h0, "r0_busy_a");
        expect_v(1, 1, 1, 32'h0, "r0_busy_b");
        tick();

        // Write-port conflict on r7
        wr(0, 0, 7, 32'h11);
        wr(0, 1, 7, 32'h22);
        set_rd(0, 0, 7);
        expect_v(0, 0, 0, 32'h22, "conflict_bypass");
        tick();
        idle();
        expect_v(0, 0, 0, 32'h22, "conflict_stored");
        tick();

        // Scoreboard on r9
        alloc(0, 9);
        set_rd(0, 1, 9);
        expect_v(0, 1, 1, 32'h0, "busy_not_yet");
        tick();
        idle();
        wr(0, 0, 9, 32'h90);
        alloc(0, 9);
        expect_v(0, 1, 1, 32'h1, "busy_after_alloc");
        expect_v(0, 0, 1, 32'h90, "r9_bypass");
        tick();
        idle();
        wr(0, 1, 9, 32'h99);
        expect_v(0, 1, 1, 32'h1, "busy_alloc_wins");
        tick();
        idle();
        expect_v(0, 1, 1, 32'h0, "busy_cleared");
        expect_v(0, 0, 1, 32'h99, "r9_stored");
        tick();

        // Mid-operation reset
        for (int i = 1; i < DEPTH; i++) begin
            idle();
            wr(0, 0, i, 32'h01010101 * i);
            tick();
        end
        idle();
        alloc(0, 3);
        set_rd(0, 1, 3);
        tick();
        idle();
        expect_v(0, 1, 1, 32'h1, "busy_r3_set");
        expect_v(0, 0, 1, 32'h03030303, "r3_filled");
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_v(0, 2, 0, 32'h0, "ready_after_midrst");
        expect_v(0, 1, 1, 32'h0, "busy_r3_midrst");
        expect_v(0, 0, 1, 32'h0, "r3_during_clear");
        tick();
        for (int i = 1; i < DEPTH; i++) begin
            expect_v(0, 2, 0, 32'h0, "ready_midrst_clear");
            tick();
        end
        expect_v(0, 2, 0, 32'h1, "ready_midrst_rise");
        set_rd(0, 1, 3);
        expect_v(0, 1, 1, 32'h0, "busy_r3_after_clear");
        tick();
        read_all_zero("midrst_readback");

        tick();
        tick();
        if (q_exp.size() != 0) begin
            n_err++;
            $display("FAIL queue_drain: got %0d pending expected 0", q_exp.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file, successor to the single-write/dual-read core register file.
- Adds:
  - configurable depth, width and port counts
  - optional same-cycle write-to-read bypass
  - per-register busy scoreboard for in-flight destinations
  - sequenced reset clear with a ready flag
- Sits between decode/issue (read and allocate) and writeback (write and clear busy) in the pipelined core.

Parameters:
- DATA_WIDTH, 32, bits per register.
- DEPTH, 32, number of registers; power of two, >= 2.
- NUM_RD, 2, number of read ports.
- NUM_WR, 1, number of write ports (1..4).
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching reads; 0 = reads return stored value.
- ZERO_REG, 1, 1 = register 0 is hardwired to zero.
- ADDR_W, $clog2(DEPTH), derived register index width; do not override.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- ready  out  1  high once the clear sequence has finished; low during clear.
- rd_addr  in  NUM_RD*ADDR_W  read indices, port k at bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_WIDTH  read data per port.
- rd_busy  out  NUM_RD  scoreboard busy bit of each addressed register.
- wr_en  in  NUM_WR  write enable per write port.
- wr_addr  in  NUM_WR*ADDR_W  write indices.
- wr_data  in  NUM_WR*DATA_WIDTH  write data.
- alloc_en  in  1  mark alloc_addr busy (instruction issued with destination).
- alloc_addr  in  ADDR_W  register to mark busy.

Behaviour:
- Init state machine, states CLEAR and RUN:
  - rst=1 → state CLEAR, clear counter = 0, all busy bits = 0, ready = 0. Applies on any cycle, including mid-RUN.
  - In CLEAR: one entry per cycle, entry[counter] <= 0, counter++. After entry DEPTH-1 is written, go to RUN and assert ready on the next cycle.
  - After rst deasserts, ready therefore rises exactly DEPTH cycles later.
  - rst held high keeps the state machine in CLEAR with counter 0.
- During CLEAR:
  - wr_en and alloc_en are ignored.
  - rd_data = 0 and rd_busy = 0 on all ports.
- Reads (RUN):
  - Combinational, zero latency.
  - rd_data[k] = array[rd_addr[k]].
  - Exception: if ZERO_REG=1 and rd_addr[k]=0, rd_data[k] = 0 regardless of any write.
- Bypass (BYPASS=1):
  - If any wr_en[j] is high with wr_addr[j] == rd_addr[k] (and not zero register), rd_data[k] = that wr_data[j] in the same cycle.
  - The highest-numbered matching write port wins.
- Writes (RUN): on the rising edge, array[wr_addr[j]] <= wr_data[j] for each enabled port.
  - Same address on multiple ports: highest index j wins.
  - Writes to register 0 are dropped when ZERO_REG=1.
- Scoreboard (RUN):
  - A write clears busy[wr_addr[j]].
  - alloc_en sets busy[alloc_addr].
  - Alloc and write to the same register in one cycle: busy ends set, because the newer allocation wins.
  - Alloc to register 0 with ZERO_REG=1 is ignored; busy[0] stays 0.
  - rd_busy[k] = busy[rd_addr[k]], registered state only. A same-cycle clear is not bypassed; it is visible the next cycle.
- Out-of-range indices cannot occur: DEPTH is a power of two.

Decomposition:
- Shared package regfile_pkg holds:
  - enum rf_state_e {RF_CLEAR, RF_RUN}
  - localparams for default DATA_WIDTH/DEPTH
- Sub-module regfile_scoreboard:
  - DEPTH busy bits, NUM_WR clear ports, one set port, NUM_RD lookup ports, synchronous clear on rst.
  - Instantiated once.
- The storage array, bypass muxing and init FSM remain in regfile_mp.

Test Plan:
1. Reset/clear, DEPTH=32:
   - Stimulus: pulse rst 1 cycle.
   - Response: ready=0 for exactly 32 cycles, then 1. All 32 reads return 0. Writes issued during clear are lost (read back 0).
2. Write/read with bypass:
   - Stimulus: write r5=0xDEADBEEF on port 0 while reading r5.
   - Response: same-cycle rd_data=0xDEADBEEF. Next cycle, with BYPASS=0, the same-cycle read returns the old value 0 and the next cycle returns 0xDEADBEEF.
3. Zero register:
   - Stimulus: write r0=0x1234 and alloc r0.
   - Response: read r0 = 0 (including bypass cycle), rd_busy = 0.
4. Write-port conflict, NUM_WR=2:
   - Stimulus: both ports write r7, port0=0x11, port1=0x22.
   - Response: bypassed and stored value = 0x22.
5. Scoreboard:
   - Stimulus: alloc r9; next cycle write r9 and alloc r9 together; then write r9 only.
   - Response: rd_busy(r9) = 1, then stays 1 after the combined cycle, then 0 one cycle after the lone write.
6. Mid-operation reset:
   - Stimulus: fill r1..r31 with nonzero values, set busy on r3, assert rst.
   - Response: next cycle ready=0 and busy(r3)=0. After 32 cycles all registers read 0.
